// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM round-robin arbiter.
package sram_arb_pkg;

  // Arbiter ownership state: free, or locked to one port for a burst.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } arb_state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Outstanding read: which port gets the data returned next cycle.
  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-input round-robin pick; rr_ptr breaks ties.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic rr_ptr,
  output logic gnt_idx,
  output logic gnt_valid
);

  // Lone requester wins outright; on contention the preferred port wins.
  always_comb begin
    gnt_valid = valid0 | valid1;
    gnt_idx   = PORT0;
    if (valid0 && valid1) begin
      gnt_idx = rr_ptr;
    end else if (valid1) begin
      gnt_idx = PORT1;
    end
  end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Two-master arbiter for a single-port SRAM: one beat per cycle, round-robin
// fairness, locked bursts with beat limit and idle timeout, per-port read strobe.
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned IDLE_TMO  = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  // Port 0
  input  logic                 req_valid_0,
  output logic                 req_ready_0,
  input  logic                 req_write_0,
  input  logic                 req_last_0,
  input  logic [ADDR_BITS-1:0] req_addr_0,
  input  logic [DATA_BITS-1:0] req_wdata_0,
  output logic                 rsp_valid_0,
  // Port 1
  input  logic                 req_valid_1,
  output logic                 req_ready_1,
  input  logic                 req_write_1,
  input  logic                 req_last_1,
  input  logic [ADDR_BITS-1:0] req_addr_1,
  input  logic [DATA_BITS-1:0] req_wdata_1,
  output logic                 rsp_valid_1,
  // Shared read data
  output logic [DATA_BITS-1:0] rsp_rdata,
  // SRAM pins
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_din,
  input  logic [DATA_BITS-1:0] mem_dout
);

  localparam int unsigned BeatBits = $clog2(MAX_BURST + 1);
  localparam int unsigned IdleBits = $clog2(IDLE_TMO + 1);
  // Counter values seen on the final allowed beat / final idle cycle.
  localparam logic [BeatBits-1:0] BeatLast   = BeatBits'(MAX_BURST - 1);
  localparam logic [IdleBits-1:0] IdleLast   = IdleBits'(IDLE_TMO - 1);
  localparam bit                  SingleBeat = (MAX_BURST == 1);

  arb_state_e            state;
  logic                  rr_ptr;
  logic [BeatBits-1:0]   beat_cnt;
  logic [IdleBits-1:0]   idle_cnt;
  rd_tag_t               rd_tag;

  logic                  arb_idx;
  logic                  arb_valid;
  logic                  gnt_port;
  logic                  gnt_ok;
  logic                  sel_valid;
  logic                  sel_write;
  logic                  sel_last;
  logic [ADDR_BITS-1:0]  sel_addr;
  logic [DATA_BITS-1:0]  sel_wdata;
  logic                  accepted;

  rr_arb2 u_rr_arb2 (
    .valid0    (req_valid_0),
    .valid1    (req_valid_1),
    .rr_ptr    (rr_ptr),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  // Decide which port may move a beat this cycle; reset blocks all grants.
  always_comb begin
    gnt_port = arb_idx;
    gnt_ok   = 1'b0;
    case (state)
      StIdle: begin
        gnt_port = arb_idx;
        gnt_ok   = arb_valid;
      end
      StOwn0: begin
        gnt_port = PORT0;
        gnt_ok   = 1'b1;
      end
      StOwn1: begin
        gnt_port = PORT1;
        gnt_ok   = 1'b1;
      end
      default: begin
        gnt_port = PORT0;
        gnt_ok   = 1'b0;
      end
    endcase
    if (!rstn) begin
      gnt_ok = 1'b0;
    end
  end

  // Mux the granted port's request fields.
  always_comb begin
    if (gnt_port == PORT1) begin
      sel_valid = req_valid_1;
      sel_write = req_write_1;
      sel_last  = req_last_1;
      sel_addr  = req_addr_1;
      sel_wdata = req_wdata_1;
    end else begin
      sel_valid = req_valid_0;
      sel_write = req_write_0;
      sel_last  = req_last_0;
      sel_addr  = req_addr_0;
      sel_wdata = req_wdata_0;
    end
  end

  // Handshake and SRAM drive, all in the cycle of acceptance.
  always_comb begin
    req_ready_0 = gnt_ok & (gnt_port == PORT0);
    req_ready_1 = gnt_ok & (gnt_port == PORT1);
    accepted    = gnt_ok & sel_valid;
    mem_en      = accepted;
    mem_we      = accepted & sel_write;
    mem_addr    = accepted ? sel_addr : '0;
    mem_din     = accepted ? sel_wdata : '0;
  end

  // Read return; gating with rstn drops a read that was in flight at reset.
  always_comb begin
    rsp_valid_0 = rstn & rd_tag.valid & (rd_tag.port == PORT0);
    rsp_valid_1 = rstn & rd_tag.valid & (rd_tag.port == PORT1);
    rsp_rdata   = mem_dout;
  end

  // Ownership FSM, fairness pointer, burst/idle counters and read tag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= StIdle;
      rr_ptr   <= PORT0;
      beat_cnt <= '0;
      idle_cnt <= '0;
      rd_tag   <= '0;
    end else begin
      rd_tag.valid <= accepted & ~sel_write;
      rd_tag.port  <= gnt_port;
      case (state)
        StIdle: begin
          if (accepted) begin
            if (sel_last || SingleBeat) begin
              rr_ptr <= ~gnt_port;
            end else begin
              state    <= (gnt_port == PORT0) ? StOwn0 : StOwn1;
              beat_cnt <= BeatBits'(1);
              idle_cnt <= '0;
            end
          end
        end
        StOwn0, StOwn1: begin
          if (accepted) begin
            beat_cnt <= beat_cnt + BeatBits'(1);
            idle_cnt <= '0;
            if (sel_last || (beat_cnt == BeatLast)) begin
              state    <= StIdle;
              rr_ptr   <= ~gnt_port;
              beat_cnt <= '0;
            end
          end else if (idle_cnt == IdleLast) begin
            // Owner went quiet too long: hand the SRAM back.
            state    <= StIdle;
            rr_ptr   <= ~gnt_port;
            beat_cnt <= '0;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + IdleBits'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Self-checking bench for sram_rr_arbiter with an in-bench SRAM and a
// transaction-level reference model of grants, locks and read returns.
module tb_sram_rr_arbiter;

  localparam int AB  = 10;
  localparam int DB  = 32;
  localparam int MB  = 8;
  localparam int TMO = 4;

  typedef struct packed {
    logic          rdy1;
    logic          rdy0;
    logic          en;
    logic          we;
    logic [AB-1:0] addr;
    logic [DB-1:0] din;
    logic          rv1;
    logic          rv0;
  } obs_t;

  logic          clk;
  logic          rstn;
  logic          vld [2];
  logic          wr  [2];
  logic          lst [2];
  logic [AB-1:0] adr [2];
  logic [DB-1:0] wd  [2];
  logic          req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1;
  logic [DB-1:0] rsp_rdata;
  logic          mem_en, mem_we;
  logic [AB-1:0] mem_addr;
  logic [DB-1:0] mem_din;
  logic [DB-1:0] mem_dout;

  // Bench-side SRAM with a preload path used only while the DUT is in reset.
  logic [DB-1:0] tb_mem [0:(1<<AB)-1];
  logic          pre_en;
  logic [AB-1:0] pre_addr;
  logic [DB-1:0] pre_data;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int            own    = -1;
  int            beats  = 0;
  int            idles  = 0;
  int            prefer = 0;
  int            pend   = -1;
  logic [DB-1:0] pend_data;
  logic [DB-1:0] shadow [0:(1<<AB)-1];
  obs_t          exp_o;
  int            exp_acc;

  sram_rr_arbiter #(
    .ADDR_BITS (AB),
    .DATA_BITS (DB),
    .MAX_BURST (MB),
    .IDLE_TMO  (TMO)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid_0 (vld[0]),
    .req_ready_0 (req_ready_0),
    .req_write_0 (wr[0]),
    .req_last_0  (lst[0]),
    .req_addr_0  (adr[0]),
    .req_wdata_0 (wd[0]),
    .rsp_valid_0 (rsp_valid_0),
    .req_valid_1 (vld[1]),
    .req_ready_1 (req_ready_1),
    .req_write_1 (wr[1]),
    .req_last_1  (lst[1]),
    .req_addr_1  (adr[1]),
    .req_wdata_1 (wd[1]),
    .rsp_valid_1 (rsp_valid_1),
    .rsp_rdata   (rsp_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en) begin
      tb_mem[pre_addr] <= pre_data;
    end else if (mem_en) begin
      if (mem_we) tb_mem[mem_addr] <= mem_din;
      else        mem_dout <= tb_mem[mem_addr];
    end
  end

  function automatic obs_t obs_now();
    obs_t o;
    o.rdy1 = req_ready_1;
    o.rdy0 = req_ready_0;
    o.en   = mem_en;
    o.we   = mem_we;
    o.addr = mem_addr;
    o.din  = mem_din;
    o.rv1  = rsp_valid_1;
    o.rv0  = rsp_valid_0;
    return o;
  endfunction

  // Port that moved a beat this cycle, -1 if none.
  function automatic int obs_grant();
    if (!mem_en) return -1;
    return req_ready_1 ? 1 : 0;
  endfunction

  // Expected outputs for the current inputs.
  task automatic model_eval();
    int g;
    exp_o   = '0;
    exp_acc = -1;
    if (rstn) begin
      if (own < 0) begin
        g = -1;
        if (vld[0] && vld[1]) g = prefer;
        else if (vld[0])      g = 0;
        else if (vld[1])      g = 1;
        if (g == 0) exp_o.rdy0 = 1'b1;
        if (g == 1) exp_o.rdy1 = 1'b1;
        exp_acc = g;
      end else begin
        if (own == 0) exp_o.rdy0 = 1'b1;
        else          exp_o.rdy1 = 1'b1;
        if (vld[own]) exp_acc = own;
      end
    end
    if (exp_acc >= 0) begin
      exp_o.en   = 1'b1;
      exp_o.we   = wr[exp_acc];
      exp_o.addr = adr[exp_acc];
      exp_o.din  = wd[exp_acc];
    end
    exp_o.rv0 = rstn && (pend == 0);
    exp_o.rv1 = rstn && (pend == 1);
  endtask

  // Advance the model by one clock using the current inputs.
  task automatic model_update();
    if (!rstn) begin
      own = -1; prefer = 0; beats = 0; idles = 0; pend = -1;
    end else begin
      pend = -1;
      if (exp_acc >= 0) begin
        if (wr[exp_acc]) begin
          shadow[adr[exp_acc]] = wd[exp_acc];
        end else begin
          pend      = exp_acc;
          pend_data = shadow[adr[exp_acc]];
        end
      end
      if (own < 0) begin
        if (exp_acc >= 0) begin
          if (lst[exp_acc] || MB == 1) prefer = 1 - exp_acc;
          else begin own = exp_acc; beats = 1; idles = 0; end
        end
      end else if (exp_acc >= 0) begin
        beats++;
        idles = 0;
        if (lst[exp_acc] || beats == MB) begin prefer = 1 - own; own = -1; end
      end else begin
        idles++;
        if (idles == TMO) begin prefer = 1 - own; own = -1; end
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic new_beat(input int p, input logic last);
    wr[p]  = 1'($urandom_range(0, 1));
    lst[p] = last;
    adr[p] = AB'($urandom_range(0, 7));
    wd[p]  = $urandom();
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < 2; p++) begin
      vld[p] = 1'b0; wr[p] = 1'b0; lst[p] = 1'b1; adr[p] = '0; wd[p] = '0;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    settle();
    advance();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    vld[0] = 1'b1; vld[1] = 1'b1; wr[0] = 1'b1;
    rstn = 1'b0;
    pre_en = 1'b1; pre_addr = AB'(5); pre_data = 32'hDEADBEEF;
    shadow[5] = 32'hDEADBEEF;
    for (int i = 0; i < 2; i++) begin
      settle();
      if ({req_ready_1, req_ready_0, mem_en, mem_we} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_force cyc%0d got=%b want=0000", i,
                 {req_ready_1, req_ready_0, mem_en, mem_we});
      end
      checks++;
      advance();
      pre_en = 1'b0;
    end
    rstn = 1'b1;
    idle_inputs();
    settle();
    if ({rsp_valid_1, rsp_valid_0} !== 2'b00) begin
      failures++;
      $display("FAIL reset_rsp got=%b want=00", {rsp_valid_1, rsp_valid_0});
    end
    checks++;
    if (obs_now() !== exp_o) begin
      failures++;
      $display("FAIL reset_obs got=%h want=%h", obs_now(), exp_o);
    end
    checks++;
    advance();
  endtask

  task automatic test_single_read();
    vld[0] = 1'b1; wr[0] = 1'b0; lst[0] = 1'b1; adr[0] = AB'(5);
    settle();
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== AB'(5)) begin
      failures++;
      $display("FAIL single_rd_issue got en=%b we=%b addr=%h want en=1 we=0 addr=005",
               mem_en, mem_we, mem_addr);
    end
    checks++;
    if (obs_now() !== exp_o) begin
      failures++;
      $display("FAIL single_rd_obs0 got=%h want=%h", obs_now(), exp_o);
    end
    checks++;
    advance();
    vld[0] = 1'b0;
    settle();
    if (rsp_valid_0 !== 1'b1 || rsp_valid_1 !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_rd_rsp got v0=%b v1=%b data=%h want v0=1 v1=0 data=deadbeef",
               rsp_valid_0, rsp_valid_1, rsp_rdata);
    end
    checks++;
    advance();
  endtask

  task automatic test_back_to_back();
    logic [DB-1:0] data;
    data = $urandom();
    vld[1] = 1'b1; wr[1] = 1'b1; lst[1] = 1'b1; adr[1] = AB'(10'h20); wd[1] = data;
    settle();
    if (obs_now() !== exp_o) begin
      failures++;
      $display("FAIL raw_write got=%h want=%h", obs_now(), exp_o);
    end
    checks++;
    advance();
    wr[1] = 1'b0;
    settle();
    if (obs_now() !== exp_o) begin
      failures++;
      $display("FAIL raw_read got=%h want=%h", obs_now(), exp_o);
    end
    checks++;
    advance();
    vld[1] = 1'b0;
    settle();
    if (rsp_valid_1 !== 1'b1 || rsp_rdata !== data) begin
      failures++;
      $display("FAIL raw_data got v1=%b data=%h want v1=1 data=%h", rsp_valid_1, rsp_rdata, data);
    end
    checks++;
    advance();
  endtask

  task automatic test_alternate();
    do_reset();
    vld[0] = 1'b1; vld[1] = 1'b1;
    new_beat(0, 1'b1);
    new_beat(1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      settle();
      if (obs_grant() !== i % 2) begin
        failures++;
        $display("FAIL alternate cyc%0d grant got=%0d want=%0d", i, obs_grant(), i % 2);
      end
      checks++;
      if (obs_now() !== exp_o) begin
        failures++;
        $display("FAIL alternate_obs cyc%0d got=%h want=%h", i, obs_now(), exp_o);
      end
      checks++;
      advance();
      if (exp_acc >= 0) new_beat(exp_acc, 1'b1);
    end
  endtask

  task automatic test_locked_burst();
    int want;
    do_reset();
    vld[1] = 1'b1;
    new_beat(1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      vld[0] = (i < 3);
      wr[0]  = 1'b1;
      lst[0] = (i == 2);
      adr[0] = AB'(10'h10 + i);
      wd[0]  = $urandom();
      settle();
      want = (i < 3) ? 0 : 1;
      if (obs_grant() !== want || req_ready_1 !== (i == 3)) begin
        failures++;
        $display("FAIL locked_burst cyc%0d got grant=%0d rdy1=%b want grant=%0d rdy1=%b",
                 i, obs_grant(), req_ready_1, want, (i == 3));
      end
      checks++;
      if (obs_now() !== exp_o) begin
        failures++;
        $display("FAIL locked_burst_obs cyc%0d got=%h want=%h", i, obs_now(), exp_o);
      end
      checks++;
      advance();
    end
  endtask

  task automatic test_max_burst();
    int want;
    do_reset();
    vld[0] = 1'b1; vld[1] = 1'b1;
    new_beat(0, 1'b0);
    new_beat(1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      settle();
      want = (i == 8) ? 1 : 0;
      if (obs_grant() !== want) begin
        failures++;
        $display("FAIL max_burst cyc%0d grant got=%0d want=%0d", i, obs_grant(), want);
      end
      checks++;
      if (obs_now() !== exp_o) begin
        failures++;
        $display("FAIL max_burst_obs cyc%0d got=%h want=%h", i, obs_now(), exp_o);
      end
      checks++;
      advance();
      if (exp_acc == 0) new_beat(0, 1'b0);
      if (exp_acc == 1) vld[1] = 1'b0;
    end
  endtask

  task automatic test_timeout();
    int want;
    do_reset();
    vld[1] = 1'b1;
    new_beat(1, 1'b1);
    new_beat(0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      // Owner reappears exactly when the lock has just timed out.
      vld[0] = (i < 2) || (i == 6);
      settle();
      want = (i < 2) ? 0 : (i == 6) ? 1 : -1;
      if (obs_grant() !== want || req_ready_1 !== (i == 6)) begin
        failures++;
        $display("FAIL timeout cyc%0d got grant=%0d rdy1=%b want grant=%0d rdy1=%b",
                 i, obs_grant(), req_ready_1, want, (i == 6));
      end
      checks++;
      if (obs_now() !== exp_o) begin
        failures++;
        $display("FAIL timeout_obs cyc%0d got=%h want=%h", i, obs_now(), exp_o);
      end
      checks++;
      advance();
      if (exp_acc == 0) new_beat(0, 1'b0);
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    vld[0] = 1'b1; wr[0] = 1'b0; lst[0] = 1'b1; adr[0] = AB'(3);
    settle();
    advance();
    rstn = 1'b0;
    vld[1] = 1'b1; wr[0] = 1'b1; wr[1] = 1'b1; lst[1] = 1'b1;
    settle();
    if ({rsp_valid_1, rsp_valid_0, req_ready_1, req_ready_0} !== 4'b0000) begin
      failures++;
      $display("FAIL inflight_drop got rsp=%b rdy=%b want rsp=00 rdy=00",
               {rsp_valid_1, rsp_valid_0}, {req_ready_1, req_ready_0});
    end
    checks++;
    advance();
    rstn = 1'b1;
    settle();
    if (obs_grant() !== 0 || rsp_valid_0 !== 1'b0) begin
      failures++;
      $display("FAIL inflight_regrant got grant=%0d rsp0=%b want grant=0 rsp0=0",
               obs_grant(), rsp_valid_0);
    end
    checks++;
    advance();
  endtask

  task automatic test_random();
    logic hold [2];
    do_reset();
    hold[0] = 1'b0; hold[1] = 1'b0;
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!hold[p]) begin
          vld[p] = ($urandom_range(0, 3) != 0);
          new_beat(p, 1'($urandom_range(0, 2) != 0));
        end
      end
      settle();
      if (obs_now() !== exp_o) begin
        failures++;
        $display("FAIL random_obs cyc%0d got=%h want=%h", i, obs_now(), exp_o);
      end
      checks++;
      if ((exp_o.rv0 || exp_o.rv1) && rsp_rdata !== pend_data) begin
        failures++;
        $display("FAIL random_rdata cyc%0d got=%h want=%h", i, rsp_rdata, pend_data);
      end
      checks++;
      for (int p = 0; p < 2; p++) hold[p] = vld[p] && (exp_acc != p);
      advance();
    end
  endtask

  initial begin
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    rstn = 1'b0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_alternate();
    test_locked_burst();
    test_max_burst();
    test_timeout();
    test_reset_inflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_rr_arbiter.md
# sram_rr_arbiter

Two-requester arbiter that shares one single-port SRAM (`sp_sram`, 1-cycle registered read) between two word-addressed masters, e.g. the APB slave path and a DMA/debug port. It grants one beat per cycle with round-robin fairness and supports locked bursts, so a multi-beat sequence is not interleaved. It also returns read data with a per-port response strobe. It drives the SRAM control pins directly and sits between the requesters and the memory macro.

## Interface
Parameters:
- `ADDR_BITS`, 10: SRAM word-address width.
- `DATA_BITS`, 32: data width.
- `MAX_BURST`, 8: maximum beats per locked ownership (≥1).
- `IDLE_TMO`, 4: consecutive idle owner cycles before a lock is forcibly released (≥1).

Ports (n = 0, 1):
- `clk`  in  1  single clock; all logic on posedge.
- `rstn`  in  1  reset; synchronous, active-low.
- `req_valid_n`  in  1  beat request.
- `req_ready_n`  out  1  beat accepted this cycle when valid & ready.
- `req_write_n`  in  1  1 = write, 0 = read.
- `req_last_n`  in  1  final beat of the sequence; tie high for single beats.
- `req_addr_n`  in  ADDR_BITS  word address.
- `req_wdata_n`  in  DATA_BITS  write data.
- `rsp_valid_n`  out  1  read data valid on `rsp_rdata`.
- `rsp_rdata`  out  DATA_BITS  shared read data, equal to `mem_dout`.
- `mem_en`  out  1  SRAM enable.
- `mem_we`  out  1  SRAM write enable.
- `mem_addr`  out  ADDR_BITS  SRAM address.
- `mem_din`  out  DATA_BITS  SRAM write data.
- `mem_dout`  in  DATA_BITS  SRAM read data, valid the cycle after a read enable.

## Operation
- FSM states: IDLE, OWN0, OWN1.
- Registers: `rr_ptr` (preferred port, reset 0), `beat_cnt` ($clog2(MAX_BURST+1) bits), `idle_cnt` ($clog2(IDLE_TMO+1) bits).
- IDLE:
  - One valid port: grant it.
  - Both valid: grant `rr_ptr`.
  - Granted port gets `req_ready`=1 and its beat goes to the SRAM in the same cycle.
  - If the accepted beat has `req_last`=1 or MAX_BURST==1: stay IDLE, `rr_ptr` <= other port.
  - Otherwise go to OWNn with `beat_cnt`=1 and `idle_cnt`=0.
- OWNn:
  - Only port n is ready; the other port's `req_ready` is 0.
  - On an accepted beat: `beat_cnt`++ and `idle_cnt` <= 0.
  - If that beat has `req_last`, or `beat_cnt`+1 == MAX_BURST: go to IDLE, `rr_ptr` <= other port.
  - Cycle without valid on port n: `idle_cnt`++. When `idle_cnt` reaches IDLE_TMO, go to IDLE and `rr_ptr` <= other port; no beat is granted in that cycle.
- SRAM mux, combinational from the accepted beat:
  - `mem_en` = accepted.
  - `mem_we` = accepted & `req_write`.
  - `mem_addr` and `mem_din` come from the granted port; both are 0 when no beat is accepted.
- Read return:
  - Register `rd_tag` = {valid, port}, set from an accepted read.
  - `rsp_valid_n` = `rd_tag` valid & port==n, asserted exactly 1 cycle after acceptance.
  - Writes produce no response.
- Reset:
  - While `rstn`=0, `req_ready_n`, `mem_en` and `mem_we` are forced 0 combinationally.
  - At the clock edge: state IDLE, `rr_ptr`=0, counters 0, `rd_tag` cleared, so `rsp_valid_n`=0.
  - A read in flight at reset is dropped without a response.
- After reset, `rsp_rdata` follows `mem_dout` and is don't-care unless a `rsp_valid` is high.

## Timing
- Accept-to-SRAM latency is 0 cycles (same cycle). Read data and `rsp_valid` arrive 1 cycle after acceptance.
- Throughput is 1 beat/cycle total. Port switch has no bubble: the last beat of one owner and the first beat of the other are in consecutive cycles.
- Same-address read immediately after a write in the next cycle returns the new data, per the `sp_sram` write-then-read order.
- `req_*` must stay stable while valid & !ready. The arbiter may drop `req_ready` only when a beat is not accepted.
- Boundaries:
  - MAX_BURST beats without `req_last` end the lock. The next beat from the same port re-arbitrates in IDLE.
  - Simultaneous timeout and a newly arriving valid from the owner: the timeout wins.

## Structure
- Package `sram_arb_pkg` holds:
  - the state enum (IDLE, OWN0, OWN1);
  - the port-index constants `PORT0`=0 and `PORT1`=1;
  - the `rd_tag` struct.
- Sub-module `rr_arb2`: combinational two-input round-robin pick from (`valid0`, `valid1`, `rr_ptr`) to grant index and grant valid.
- `sp_sram` is instantiated by the bench and the top level, not inside this block.

## Test plan
- Reset, then a port-0 single read of addr 0x005 with preloaded 0xDEADBEEF: `mem_en`=1, `mem_we`=0, `mem_addr`=0x005 in cycle t; `rsp_valid_0`=1 and `rsp_rdata`=0xDEADBEEF in t+1; `rsp_valid_1` stays 0.
- Both ports valid with continuous single beats for 6 cycles: grants alternate 0,1,0,1,0,1 with no idle cycle.
- Port 0 bursts 3 writes (addrs 0x10–0x12, last on beat 3) while port 1 is valid: port 1 is not ready until the cycle after beat 3, then is granted immediately.
- Port 0 bursts with `req_last` never set and MAX_BURST=8: the lock releases after 8 beats and waiting port 1 gets the 9th grant.
- Port 0 stalls valid mid-burst for 4 cycles with IDLE_TMO=4: lock released and port 1 granted in the following cycle.
- Assert `rstn`=0 the cycle after a read acceptance: no `rsp_valid`, state returns to IDLE, the next grant to simultaneous requesters goes to port 0.
